// File: rtl/ce_pkg.sv
// Shared types and helpers for the convolution-element controller.
// State encoding and a clog2 that never returns less than one bit.
package ce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ce_state_e;

  function automatic int clog2w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ce_wrap_cnt.sv
// Modulo-MAX counter; wrap is high on the increment that returns to 0.
// Chained as channel -> column -> row address generator.
module ce_wrap_cnt #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign wrap  = inc && (value_q == LAST);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (wrap) begin
      value_d = '0;
    end else if (inc) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/ce_ctrl.sv
// Sequencer for one convolution layer: walks (row, col, ch), tracks results.
// Optional stall counter enabled by defining CE_CTRL_PERF_EN.
module ce_ctrl
  import ce_pkg::*;
#(
  parameter  int CL_IN  = 3,
  parameter  int KERNEL = 3,
  parameter  int IMG_W  = 5,
  parameter  int IMG_H  = 5,
  localparam int OUT_W  = IMG_W - KERNEL + 1,
  localparam int OUT_H  = IMG_H - KERNEL + 1,
  localparam int CW     = clog2w(CL_IN),
  localparam int XW     = clog2w(OUT_W),
  localparam int YW     = clog2w(OUT_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          win_valid,
  input  logic          ce_en_out,
  output logic          ce_en_in,
  output logic [CW-1:0] ch_idx,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   stall_cnt
);

  localparam int NPIX = OUT_W * OUT_H;
  localparam int PW   = clog2w(NPIX + 2);

  ce_state_e state_q;
  ce_state_e state_d;

  logic [PW-1:0] out_q;
  logic [PW-1:0] out_d;
  logic [PW-1:0] pix_q;
  logic [PW-1:0] pix_d;
  logic [PW-1:0] pix_now;
  logic          err_q;
  logic          err_d;

  logic run_st;
  logic active;
  logic start_acc;
  logic beat;
  logic ch_wrap;
  logic col_wrap;
  logic row_wrap;

  assign run_st    = (state_q == RUN);
  assign active    = run_st || (state_q == DRAIN);
  assign start_acc = (state_q == IDLE) && start;
  assign beat      = run_st && win_valid && !abort;

  ce_wrap_cnt #(.MAX(CL_IN), .W(CW)) u_ch (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc   (beat),
    .value (ch_idx),
    .wrap  (ch_wrap)
  );

  ce_wrap_cnt #(.MAX(OUT_W), .W(XW)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc   (ch_wrap),
    .value (col),
    .wrap  (col_wrap)
  );

  ce_wrap_cnt #(.MAX(OUT_H), .W(YW)) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc   (col_wrap),
    .value (row),
    .wrap  (row_wrap)
  );

  // A result on the beat that completes its pixel is legal.
  assign pix_now = pix_q + PW'(ch_wrap);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (row_wrap) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                    state_d = IDLE;
        else if (out_q >= PW'(NPIX))  state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    pix_d = pix_q;
    err_d = err_q;
    if (start_acc) begin
      out_d = '0;
      pix_d = '0;
      err_d = 1'b0;
    end else begin
      if (ch_wrap) begin
        pix_d = pix_q + PW'(1);
      end
      if (ce_en_out && active && !abort && (out_q != '1)) begin
        out_d = out_q + PW'(1);
      end
      if (ce_en_out && !active) begin
        err_d = 1'b1;
      end else if (ce_en_out && (out_q >= pix_now)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end

  assign ce_en_in = beat;
  assign busy     = active;
  assign done     = (state_q == DONE);
  assign err      = err_q;

`ifdef CE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (run_st && !win_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ce_ctrl.sv
// Directed bench for ce_ctrl at CL_IN=3, 3x3 output (27 beats, 9 pixels).
// Vector table for control basics, sequences for full layers.
module tb_ce_ctrl;

  localparam int NBEAT = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        win_valid;
  logic        ce_en_out;
  logic        ce_en_in;
  logic [1:0]  ch_idx;
  logic [1:0]  col;
  logic [1:0]  row;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ce_ctrl #(
    .CL_IN  (3),
    .KERNEL (3),
    .IMG_W  (5),
    .IMG_H  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .win_valid (win_valid),
    .ce_en_out (ce_en_out),
    .ce_en_in  (ce_en_in),
    .ch_idx    (ch_idx),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [4:0] in;
    logic [3:0] fl;
    int         ch;
    int         cx;
    int         ry;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [4:0] i, input logic [3:0] f,
                              input int c, input int x, input int y);
    vec_t v;
    v.in = i;
    v.fl = f;
    v.ch = c;
    v.cx = x;
    v.ry = y;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    win_valid = 1'b0;
    ce_en_out = 1'b0;
  endtask

  // vmode 0: win_valid always 1; 1: low, high, low, ...
  // omode 0: result on completing beat; 1: result one cycle later;
  //       2: no results; 3: one bogus result on first RUN cycle only
  task automatic run_layer(input int vmode, input int omode,
                           input int start_at, input int abort_at,
                           output int beats, output logic pend);
    int  cyc;
    bit  quit;
    @(negedge clk);
    idle_in();
    start = 1'b1;
    #1;
    chk("start_en_in", ce_en_in, 0);
    chk("start_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    cyc   = 0;
    pend  = 1'b0;
    quit  = 1'b0;
    while (!quit && beats < NBEAT && cyc < 400) begin
      win_valid = (vmode == 0) ? 1'b1 : (cyc % 2 == 1);
      if (omode == 0)      ce_en_out = win_valid && (beats % 3 == 2);
      else if (omode == 1) ce_en_out = pend;
      else if (omode == 3) ce_en_out = (cyc == 0);
      else                 ce_en_out = 1'b0;
      start = win_valid && (beats == start_at);
      abort = (beats == abort_at);
      #1;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_en_in", ce_en_in, abort ? 0 : int'(win_valid));
      chk("run_ch", ch_idx, beats % 3);
      chk("run_col", col, (beats / 3) % 3);
      chk("run_row", row, beats / 9);
      if (abort) begin
        quit = 1'b1;
      end else begin
        pend = win_valid && (beats % 3 == 2);
        if (win_valid) beats++;
      end
      cyc++;
      @(negedge clk);
    end
    idle_in();
  endtask

  // Called at the negedge of the first DRAIN cycle.
  task automatic drain_check(input logic first_out, input int dlen);
    int nd;
    for (int k = 0; k < dlen; k++) begin
      win_valid = 1'b1;
      ce_en_out = (k == 0) ? first_out : 1'b0;
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_en_in", ce_en_in, 0);
      chk("drain_done", done, 0);
      @(negedge clk);
    end
    idle_in();
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (done) nd++;
      if (k == 0) chk("post_busy", busy, 0);
    end
    chk("extra_done", nd, 0);
    chk("layer_err", err, 0);
  endtask

  initial begin
    int   nb;
    logic pd;

    #200000;
    $display("FAIL watchdog: sim did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int   nb;
    logic pd;

    // in = {rst,start,abort,win_valid,ce_en_out}
    // fl = {ce_en_in,busy,done,err}
    tbl[0]  = mk(5'b10000, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(5'b00001, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(5'b00000, 4'b0001, 0, 0, 0);
    tbl[3]  = mk(5'b00000, 4'b0001, 0, 0, 0);
    tbl[4]  = mk(5'b01010, 4'b0001, 0, 0, 0);
    tbl[5]  = mk(5'b00010, 4'b1100, 0, 0, 0);
    tbl[6]  = mk(5'b00000, 4'b0100, 1, 0, 0);
    tbl[7]  = mk(5'b01000, 4'b0100, 1, 0, 0);
    tbl[8]  = mk(5'b00010, 4'b1100, 1, 0, 0);
    tbl[9]  = mk(5'b00010, 4'b1100, 2, 0, 0);
    tbl[10] = mk(5'b00110, 4'b0100, 0, 1, 0);
    tbl[11] = mk(5'b00010, 4'b0000, 0, 1, 0);
    tbl[12] = mk(5'b10000, 4'b0000, 0, 1, 0);
    tbl[13] = mk(5'b00000, 4'b0000, 0, 0, 0);

    idle_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      {rst, start, abort, win_valid, ce_en_out} = tbl[i].in;
      #1;
      chk($sformatf("v%0d_en_in", i), ce_en_in, int'(tbl[i].fl[3]));
      chk($sformatf("v%0d_busy", i), busy, int'(tbl[i].fl[2]));
      chk($sformatf("v%0d_done", i), done, int'(tbl[i].fl[1]));
      chk($sformatf("v%0d_err", i), err, int'(tbl[i].fl[0]));
      chk($sformatf("v%0d_ch", i), ch_idx, tbl[i].ch);
      chk($sformatf("v%0d_col", i), col, tbl[i].cx);
      chk($sformatf("v%0d_row", i), row, tbl[i].ry);
    end
    chk("reset_stall", stall_cnt, 0);

    // Full layer, continuous data, result on each pixel's last beat.
    run_layer(0, 0, -1, -1, nb, pd);
    chk("a_beats", nb, NBEAT);
    drain_check(1'b0, 1);

    // Toggling data, results one cycle late; last lands in DRAIN.
    run_layer(1, 1, -1, -1, nb, pd);
    chk("b_beats", nb, NBEAT);
    chk("b_pend", pd, 1);
    drain_check(pd, 2);
`ifdef CE_CTRL_PERF_EN
    chk("b_stall", stall_cnt, 27);
`else
    chk("b_stall", stall_cnt, 0);
`endif

    // Abort on the tenth beat, then replay from the origin.
    run_layer(0, 0, -1, 9, nb, pd);
    chk("c_beats", nb, 9);
    win_valid = 1'b1;
    #1;
    chk("c_busy", busy, 0);
    chk("c_done", done, 0);
    chk("c_en_in", ce_en_in, 0);
    chk("c_ch", ch_idx, 0);
    chk("c_col", col, 0);
    chk("c_row", row, 1);
    run_layer(0, 0, -1, -1, nb, pd);
    chk("c_replay_beats", nb, NBEAT);
    drain_check(1'b0, 1);

    // Stray start mid-layer must not restart it.
    run_layer(0, 0, 13, -1, nb, pd);
    chk("d_beats", nb, NBEAT);
    drain_check(1'b0, 1);

    // Early result flags err; reset with start in DRAIN wins.
    run_layer(0, 3, -1, -1, nb, pd);
    chk("e_beats", nb, NBEAT);
    #1;
    chk("e_err", err, 1);
    chk("e_drain_busy", busy, 1);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    #1;
    chk("e_pre_busy", busy, 1);
    @(negedge clk);
    idle_in();
    #1;
    chk("e_busy", busy, 0);
    chk("e_err_clr", err, 0);
    chk("e_done", done, 0);
    chk("e_en_in", ce_en_in, 0);
    chk("e_ch", ch_idx, 0);
    chk("e_col", col, 0);
    chk("e_row", row, 0);
    chk("e_stall", stall_cnt, 0);
    @(negedge clk);
    #1;
    chk("e_still_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ce_ctrl.md
CE_CTRL -- requirements
Module: ce_ctrl

Interface
REQ-001 SHALL have parameter CL_IN, default 3, input feature channels per output pixel (2..64).
REQ-002 SHALL have parameter KERNEL, default 3, kernel side (1/3/5/7).
REQ-003 SHALL have parameter IMG_W, default 5, input image width in pixels (>= KERNEL).
REQ-004 SHALL have parameter IMG_H, default 5, input image height in pixels (>= KERNEL).
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit, single-cycle layer start request.
REQ-008 SHALL have port abort, input, 1 bit, cancels the current layer.
REQ-009 SHALL have port win_valid, input, 1 bit, window and weight data for the current (row, col, ch) are present.
REQ-010 SHALL have port ce_en_out, input, 1 bit, result strobe from the convolution element.
REQ-011 SHALL have port ce_en_in, output, 1 bit, drives the convolution element's en_in.
REQ-012 SHALL have port ch_idx, output, CW=max(1,clog2(CL_IN)) bits, channel and weight-bank address.
REQ-013 SHALL have port col, output, XW=max(1,clog2(OUT_W)) bits, window column (OUT_W=IMG_W-KERNEL+1).
REQ-014 SHALL have port row, output, YW=max(1,clog2(OUT_H)) bits, window row (OUT_H=IMG_H-KERNEL+1).
REQ-015 SHALL have port busy, output, 1 bit, layer in progress.
REQ-016 SHALL have port done, output, 1 bit, one-cycle pulse on layer completion.
REQ-017 SHALL have port err, output, 1 bit, sticky protocol error.
REQ-018 SHALL have port stall_cnt, output, 32 bits, stall cycle count (see Configuration).

Function
REQ-019 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE: start=1 SHALL clear counters and err and enter RUN next cycle; start SHALL be ignored in all other states.
REQ-021 RUN: ce_en_in SHALL equal win_valid (combinational); ch_idx/col/row SHALL hold while win_valid=0.
REQ-022 Each accepted beat (ce_en_in=1) SHALL advance ch; ch wrap CL_IN-1->0 SHALL advance col; col wrap OUT_W-1->0 SHALL advance row.
REQ-023 Order SHALL be channel fastest, then column, then row; total beats = CL_IN*OUT_W*OUT_H.
REQ-024 The accepted beat at ch=CL_IN-1, col=OUT_W-1, row=OUT_H-1 SHALL move RUN->DRAIN; ce_en_in SHALL be 0 outside RUN.
REQ-025 An out counter SHALL increment on each ce_en_out in RUN or DRAIN; one result per pixel is expected.
REQ-026 DRAIN->DONE SHALL occur in the cycle after out counter reaches OUT_W*OUT_H; ce_en_out arriving on the last RUN beat SHALL still count.
REQ-027 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-028 busy SHALL be 1 in RUN and DRAIN only.
REQ-029 ce_en_out in IDLE or DONE, or the out count exceeding pixels issued, SHALL set err=1; err SHALL remain set until the next accepted start or rst.
REQ-030 abort=1 in RUN or DRAIN SHALL force IDLE next cycle with ce_en_in=0 that cycle, no done, and counters held; abort SHALL take priority over beat advance.

Reset
REQ-031 rst=1 SHALL force IDLE, ch_idx=col=row=0, out count 0, ce_en_in=0, busy=0, done=0, err=0, stall_cnt=0, overriding start and abort.

Configuration
REQ-032 With CE_CTRL_PERF_EN defined, stall_cnt SHALL count RUN cycles with win_valid=0, saturate at all-ones, and clear on accepted start.
REQ-033 Without CE_CTRL_PERF_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-034 Package ce_pkg SHALL hold the state enum and a clog2-with-min-1 width function.
REQ-035 The wrapping counter SHALL be a sub-module ce_wrap_cnt (params MAX, width; ports inc, clr, value, wrap) instantiated three times.

Verification (CL_IN=3, KERNEL=3, IMG_W=IMG_H=5: 9 pixels, 27 beats)
REQ-036 Start with win_valid held 1 -> ch_idx sequence 0,1,2 repeating for 27 cycles, (row,col) 0,0 to 2,2; ce_en_in low after beat 27; with 9 ce_en_out pulses, done pulses once; busy spans start+1 through the last DRAIN cycle.
REQ-037 Toggle win_valid 1/0 every cycle -> same address sequence over 54 RUN cycles; with PERF, stall_cnt=27.
REQ-038 Assert abort at beat 10 -> IDLE next cycle, no done, ce_en_in=0; a new start replays from (0,0,0).
REQ-039 ce_en_out pulse while IDLE -> err=1 and held; next start clears it.
REQ-040 Assert rst mid-DRAIN together with start -> all outputs reset values next cycle, IDLE.
REQ-041 Pulse start during RUN -> ignored; beat count stays 27 and exactly one done pulse.
